// File: rtl/mem_burst_arbiter.sv
// Round-robin burst arbiter sharing one memory controller port among CH_NUM write/read requester pairs.
// Optional watchdog abort of stalled bursts is compiled in with `define ARB_TIMEOUT_EN.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | no burst in flight; round-robin search from r_rr_ptr
//   S_WR_BUSY  | write burst of requester r_gnt_idx in flight until wr_burst_finish
//   S_RD_BUSY  | read burst of requester r_gnt_idx in flight until rd_burst_finish
module mem_burst_arbiter #(
  parameter int MEM_DATA_BITS  = 64,
  parameter int CH_NUM         = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            mem_clk,
  input  logic                            rst,
  input  logic [CH_NUM-1:0]               ch_wr_burst_req,
  input  logic [10*CH_NUM-1:0]            ch_wr_burst_len,
  input  logic [24*CH_NUM-1:0]            ch_wr_burst_addr,
  input  logic [MEM_DATA_BITS*CH_NUM-1:0] ch_wr_burst_data,
  output logic [CH_NUM-1:0]               ch_wr_burst_data_req,
  output logic [CH_NUM-1:0]               ch_wr_burst_finish,
  input  logic [CH_NUM-1:0]               ch_rd_burst_req,
  input  logic [10*CH_NUM-1:0]            ch_rd_burst_len,
  input  logic [24*CH_NUM-1:0]            ch_rd_burst_addr,
  output logic [CH_NUM-1:0]               ch_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0]        ch_rd_burst_data,
  output logic [CH_NUM-1:0]               ch_rd_burst_finish,
  output logic                            wr_burst_req,
  output logic [9:0]                      wr_burst_len,
  output logic [23:0]                     wr_burst_addr,
  input  logic                            wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0]        wr_burst_data,
  input  logic                            wr_burst_finish,
  output logic                            rd_burst_req,
  output logic [9:0]                      rd_burst_len,
  output logic [23:0]                     rd_burst_addr,
  input  logic                            rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0]        rd_burst_data,
  input  logic                            rd_burst_finish,
  output logic                            timeout_err
);

  localparam int unsigned NREQ = 2 * CH_NUM;
  localparam int          IW   = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_BUSY = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_gnt_idx, w_gnt_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_nxt;
  logic [9:0]      r_len, w_len_nxt;
  logic [23:0]     r_addr, w_addr_nxt;
  logic [NREQ-1:0] w_req;
  logic            w_win_found;
  logic [IW-1:0]   w_win_idx, w_win_ch, w_gnt_ch, w_gnt_inc;
  logic [9:0]      w_win_len;
  logic [23:0]     w_win_addr;

  // Modulo-NREQ add; NREQ need not be a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  always_comb begin
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      w_req[2*c]   = ch_wr_burst_req[c];
      w_req[2*c+1] = ch_rd_burst_req[c];
    end
  end

  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_win_found && w_req[wrap_add(r_rr_ptr, i)]) begin
        w_win_found = 1'b1;
        w_win_idx   = wrap_add(r_rr_ptr, i);
      end
    end
  end

  assign w_win_ch  = w_win_idx >> 1;
  assign w_gnt_ch  = r_gnt_idx >> 1;
  assign w_gnt_inc = wrap_add(r_gnt_idx, 1);

  always_comb begin
    w_win_len  = '0;
    w_win_addr = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (w_win_ch == IW'(c)) begin
        w_win_len  = w_win_idx[0] ? ch_rd_burst_len[10*c +: 10]  : ch_wr_burst_len[10*c +: 10];
        w_win_addr = w_win_idx[0] ? ch_rd_burst_addr[24*c +: 24] : ch_wr_burst_addr[24*c +: 24];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_timeout_err, w_timeout_nxt;
  logic          w_tmo_hit;

  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Held at zero while idle so every burst starts counting from zero.
  always_ff @(posedge mem_clk) begin
    if (rst || r_state == S_IDLE) r_tmo_cnt <= '0;
    else                          r_tmo_cnt <= r_tmo_cnt + TW'(1);
  end

  always_ff @(posedge mem_clk) begin
    if (rst) r_timeout_err <= 1'b0;
    else     r_timeout_err <= w_timeout_nxt;
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_idx;
    w_rr_nxt    = r_rr_ptr;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
`ifdef ARB_TIMEOUT_EN
    w_timeout_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_gnt_nxt   = w_win_idx;
          w_len_nxt   = w_win_len;
          w_addr_nxt  = w_win_addr;
          w_state_nxt = w_win_idx[0] ? S_RD_BUSY : S_WR_BUSY;
        end
      end
      S_WR_BUSY: begin
        if (wr_burst_finish) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_gnt_inc;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_nxt   = S_IDLE;
          w_rr_nxt      = w_gnt_inc;
          w_timeout_nxt = 1'b1;
        end
`endif
      end
      S_RD_BUSY: begin
        if (rd_burst_finish) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_gnt_inc;
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_state_nxt   = S_IDLE;
          w_rr_nxt      = w_gnt_inc;
          w_timeout_nxt = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt_idx <= '0;
      r_rr_ptr  <= '0;
      r_len     <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt_idx <= w_gnt_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_len     <= w_len_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  assign wr_burst_req     = (r_state == S_WR_BUSY);
  assign rd_burst_req     = (r_state == S_RD_BUSY);
  assign wr_burst_len     = r_len;
  assign wr_burst_addr    = r_addr;
  assign rd_burst_len     = r_len;
  assign rd_burst_addr    = r_addr;
  assign ch_rd_burst_data = rd_burst_data;

  // Zero-latency steering: only the granted channel of the active type sees handshakes.
  always_comb begin
    wr_burst_data = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      ch_wr_burst_data_req[c]   = (w_gnt_ch == IW'(c)) && wr_burst_req && wr_burst_data_req;
      ch_wr_burst_finish[c]     = (w_gnt_ch == IW'(c)) && wr_burst_req && wr_burst_finish;
      ch_rd_burst_data_valid[c] = (w_gnt_ch == IW'(c)) && rd_burst_req && rd_burst_data_valid;
      ch_rd_burst_finish[c]     = (w_gnt_ch == IW'(c)) && rd_burst_req && rd_burst_finish;
      if (w_gnt_ch == IW'(c)) wr_burst_data = ch_wr_burst_data[MEM_DATA_BITS*c +: MEM_DATA_BITS];
    end
  end

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Self-checking bench for mem_burst_arbiter: cycle table for routing/corner cases,
// mid-burst reset sequence, and a grant-order scoreboard with all requesters active.
module tb_mem_burst_arbiter;
  localparam int MDB = 64;
  localparam int CHN = 4;

  logic                  mem_clk = 1'b0;
  logic                  rst = 1'b1;
  logic [CHN-1:0]        ch_wr_burst_req = '0;
  logic [10*CHN-1:0]     ch_wr_burst_len;
  logic [24*CHN-1:0]     ch_wr_burst_addr;
  logic [MDB*CHN-1:0]    ch_wr_burst_data;
  logic [CHN-1:0]        ch_wr_burst_data_req, ch_wr_burst_finish;
  logic [CHN-1:0]        ch_rd_burst_req = '0;
  logic [10*CHN-1:0]     ch_rd_burst_len;
  logic [24*CHN-1:0]     ch_rd_burst_addr;
  logic [CHN-1:0]        ch_rd_burst_data_valid, ch_rd_burst_finish;
  logic [MDB-1:0]        ch_rd_burst_data;
  logic                  wr_burst_req, rd_burst_req;
  logic [9:0]            wr_burst_len, rd_burst_len;
  logic [23:0]           wr_burst_addr, rd_burst_addr;
  logic                  wr_burst_data_req = 1'b0;
  logic [MDB-1:0]        wr_burst_data;
  logic                  wr_burst_finish = 1'b0;
  logic                  rd_burst_data_valid = 1'b0;
  logic [MDB-1:0]        rd_burst_data = '0;
  logic                  rd_burst_finish = 1'b0;
  logic                  timeout_err;

  int n_vec = 0;
  int n_err = 0;
  int sb[$];

  always #5 mem_clk = ~mem_clk;

  mem_burst_arbiter #(.MEM_DATA_BITS(MDB), .CH_NUM(CHN), .TIMEOUT_CYCLES(4096)) dut (
    .mem_clk(mem_clk), .rst(rst),
    .ch_wr_burst_req(ch_wr_burst_req), .ch_wr_burst_len(ch_wr_burst_len),
    .ch_wr_burst_addr(ch_wr_burst_addr), .ch_wr_burst_data(ch_wr_burst_data),
    .ch_wr_burst_data_req(ch_wr_burst_data_req), .ch_wr_burst_finish(ch_wr_burst_finish),
    .ch_rd_burst_req(ch_rd_burst_req), .ch_rd_burst_len(ch_rd_burst_len),
    .ch_rd_burst_addr(ch_rd_burst_addr), .ch_rd_burst_data_valid(ch_rd_burst_data_valid),
    .ch_rd_burst_data(ch_rd_burst_data), .ch_rd_burst_finish(ch_rd_burst_finish),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .rd_burst_finish(rd_burst_finish),
    .timeout_err(timeout_err)
  );

  function automatic logic [23:0] req_addr(input int k);
    int c;
    c = k / 2;
    return (k % 2 != 0) ? 24'h800000 + 24'(c) * 24'h001000 : 24'(c) * 24'h020000;
  endfunction

  function automatic logic [9:0] req_len(input int k);
    int c;
    c = k / 2;
    if (k % 2 != 0) return 10'(32 + c);
    return (c == 2) ? 10'd128 : 10'(16 + c);
  endfunction

  function automatic logic [MDB-1:0] wdata(input int c);
    return 64'hDA7A_0000_0000_0000 | 64'(c * 17 + 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] wreq, rreq;
    logic       wfin, rfin, wdr, rdv;
    logic       e_wreq, e_rreq;
    logic [3:0] e_cwdr, e_crdv, e_cwf, e_crf;
    int         e_k;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int ek, w;

    for (int c = 0; c < CHN; c++) begin
      ch_wr_burst_len[10*c +: 10]  = req_len(2*c);
      ch_wr_burst_addr[24*c +: 24] = req_addr(2*c);
      ch_wr_burst_data[MDB*c +: MDB] = wdata(c);
      ch_rd_burst_len[10*c +: 10]  = req_len(2*c+1);
      ch_rd_burst_addr[24*c +: 24] = req_addr(2*c+1);
    end

    //            wreq     rreq     wfin  rfin  wdr   rdv   e_wreq e_rreq cwdr     crdv     cwf      crf      k
    tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1};
    tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4};
    tbl[5]  = '{4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1};
    tbl[6]  = '{4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 3};
    tbl[7]  = '{4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 3};
    tbl[8]  = '{4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 3};
    tbl[9]  = '{4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 3};
    tbl[10] = '{4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 3};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1};

    // Reset state
    repeat (3) @(posedge mem_clk);
    #1 rst = 1'b0;
    @(negedge mem_clk);
    chk("rst_wr_req", wr_burst_req, 0);
    chk("rst_rd_req", rd_burst_req, 0);
    chk("rst_len", wr_burst_len, 0);
    chk("rst_addr", wr_burst_addr, 0);
    chk("rst_timeout_err", timeout_err, 0);

    // Cycle table: ch2 write, drop, foreign finish, then ch1 read with 4 valid pulses
    for (int i = 0; i < 13; i++) begin
      @(posedge mem_clk);
      #1;
      ch_wr_burst_req     = tbl[i].wreq;
      ch_rd_burst_req     = tbl[i].rreq;
      wr_burst_finish     = tbl[i].wfin;
      rd_burst_finish     = tbl[i].rfin;
      wr_burst_data_req   = tbl[i].wdr;
      rd_burst_data_valid = tbl[i].rdv;
      rd_burst_data       = {$urandom, $urandom};
      @(negedge mem_clk);
      chk($sformatf("v%0d_wr_req", i), wr_burst_req, tbl[i].e_wreq);
      chk($sformatf("v%0d_rd_req", i), rd_burst_req, tbl[i].e_rreq);
      chk($sformatf("v%0d_ch_wr_data_req", i), ch_wr_burst_data_req, tbl[i].e_cwdr);
      chk($sformatf("v%0d_ch_rd_valid", i), ch_rd_burst_data_valid, tbl[i].e_crdv);
      chk($sformatf("v%0d_ch_wr_finish", i), ch_wr_burst_finish, tbl[i].e_cwf);
      chk($sformatf("v%0d_ch_rd_finish", i), ch_rd_burst_finish, tbl[i].e_crf);
      chk($sformatf("v%0d_rd_data_bcast", i), ch_rd_burst_data, rd_burst_data);
      if (tbl[i].e_k >= 0) begin
        if (tbl[i].e_k % 2 == 0) begin
          chk($sformatf("v%0d_wr_addr", i), wr_burst_addr, req_addr(tbl[i].e_k));
          chk($sformatf("v%0d_wr_len", i), wr_burst_len, req_len(tbl[i].e_k));
          chk($sformatf("v%0d_wr_data", i), wr_burst_data, wdata(tbl[i].e_k / 2));
        end else begin
          chk($sformatf("v%0d_rd_addr", i), rd_burst_addr, req_addr(tbl[i].e_k));
          chk($sformatf("v%0d_rd_len", i), rd_burst_len, req_len(tbl[i].e_k));
        end
      end
    end

    // Reset mid write burst; pending ch0 read must win first afterwards
    @(posedge mem_clk); #1;
    ch_wr_burst_req = 4'b0001;
    ch_rd_burst_req = 4'b0001;
    @(posedge mem_clk); #1;
    wr_burst_data_req = 1'b1;
    @(negedge mem_clk);
    chk("pre_rst_wr_req", wr_burst_req, 1);
    chk("pre_rst_ch_wdr", ch_wr_burst_data_req, 4'b0001);
    @(posedge mem_clk); #1;
    rst = 1'b1;
    ch_wr_burst_req = 4'b0000;
    @(posedge mem_clk); #1;
    rst = 1'b0;
    @(negedge mem_clk);
    chk("mid_rst_wr_req", wr_burst_req, 0);
    chk("mid_rst_rd_req", rd_burst_req, 0);
    chk("mid_rst_ch_wdr", ch_wr_burst_data_req, 0);
    chk("mid_rst_addr", wr_burst_addr, 0);
    @(posedge mem_clk); #1;
    wr_burst_data_req = 1'b0;
    @(negedge mem_clk);
    chk("post_rst_rd_req", rd_burst_req, 1);
    chk("post_rst_rd_addr", rd_burst_addr, req_addr(1));
    @(posedge mem_clk); #1;
    rd_burst_finish = 1'b1;
    ch_rd_burst_req = 4'b0000;
    @(negedge mem_clk);
    chk("post_rst_rd_finish", ch_rd_burst_finish, 4'b0001);
    @(posedge mem_clk); #1;
    rd_burst_finish = 1'b0;
    @(negedge mem_clk);
    chk("post_rst_idle", rd_burst_req, 0);

    // All requesters active: grant order 0..7,0 with a one-cycle gap between bursts
    @(posedge mem_clk); #1 rst = 1'b1;
    @(posedge mem_clk); #1 rst = 1'b0;
    ch_wr_burst_req = 4'hF;
    ch_rd_burst_req = 4'hF;
    for (int k = 0; k < 9; k++) sb.push_back(k % 8);
    for (int b = 0; b < 9; b++) begin
      w = 1;
      @(negedge mem_clk);
      while (!(wr_burst_req || rd_burst_req) && w < 20) begin
        @(negedge mem_clk);
        w++;
      end
      if (!(wr_burst_req || rd_burst_req)) begin
        chk($sformatf("b%0d_grant_wait", b), 0, 1);
        break;
      end
      if (b > 0) chk($sformatf("b%0d_gap_latency", b), 64'(w), 1);
      ek = sb.pop_front();
      chk($sformatf("b%0d_is_read", b), rd_burst_req, 64'(ek % 2));
      chk($sformatf("b%0d_both_req", b), wr_burst_req && rd_burst_req, 0);
      chk($sformatf("b%0d_addr", b), rd_burst_req ? rd_burst_addr : wr_burst_addr, req_addr(ek));
      chk($sformatf("b%0d_len", b), rd_burst_req ? rd_burst_len : wr_burst_len, req_len(ek));
      repeat (15) @(negedge mem_clk);
      chk($sformatf("b%0d_req_held", b), wr_burst_req || rd_burst_req, 1);
      if (ek % 2 != 0) rd_burst_finish = 1'b1;
      else             wr_burst_finish = 1'b1;
      if (b == 8) begin
        ch_wr_burst_req = 4'h0;
        ch_rd_burst_req = 4'h0;
      end
      #1;
      chk($sformatf("b%0d_ch_finish", b),
          (ek % 2 != 0) ? ch_rd_burst_finish : ch_wr_burst_finish, 64'(1 << (ek / 2)));
      @(negedge mem_clk);
      wr_burst_finish = 1'b0;
      rd_burst_finish = 1'b0;
      chk($sformatf("b%0d_gap", b), wr_burst_req || rd_burst_req, 0);
    end
    chk("scoreboard_empty", 64'(sb.size()), 0);
    chk("end_timeout_err", timeout_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
